// File: rtl/myc64_prg_loader.sv
// .PRG stream loader: header decode, one ext write per payload byte.
// Optional zero-page pointer fixup via MYC64_PRG_LOADER_FIXUP_EN.
module myc64_prg_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter logic [15:0] FIXUP_BASE     = 16'h002D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte_data,
    input  logic        i_byte_last,
    output logic        o_byte_ready,
    output logic        o_ext_we,
    output logic [15:0] o_ext_addr,
    output logic [7:0]  o_ext_data,
    input  logic        i_ext_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_DATA,
        S_WRITE,
        S_DRAIN,
        S_DONE,
        S_ERR
`ifdef MYC64_PRG_LOADER_FIXUP_EN
        ,S_FIXUP
`endif
    } state_t;

    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic        r_last;
    logic [7:0]  r_cnt;
    logic        r_byte_ready;
    logic        r_ext_we;
    logic [15:0] r_ext_addr;
    logic [7:0]  r_ext_data;
    logic        w_xfer;
    logic        w_tmo;
    logic        w_rdy_nxt;
`ifdef MYC64_PRG_LOADER_FIXUP_EN
    logic        r_fix;
    logic [2:0]  r_fidx;
`endif

    assign w_xfer       = i_byte_valid & r_byte_ready;
    assign w_tmo        = (r_cnt == LP_TMO_LAST);
    assign o_byte_ready = r_byte_ready;
    assign o_ext_we     = r_ext_we;
    assign o_ext_addr   = r_ext_addr;
    assign o_ext_data   = r_ext_data;
    assign o_busy       = (r_state != S_HDR_LO);
    assign o_done       = (r_state == S_DONE);
    assign o_err        = (r_state == S_ERR);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_HDR_LO;
        else     r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_HDR_LO: if (w_xfer) w_next = i_byte_last ? S_ERR : S_HDR_HI;
            S_HDR_HI: if (w_xfer) w_next = i_byte_last ? S_ERR : S_DATA;
            S_DATA:   if (w_xfer) w_next = S_WRITE;
            S_WRITE: begin
                if (i_ext_ready) begin
`ifdef MYC64_PRG_LOADER_FIXUP_EN
                    if (r_fix)       w_next = (r_fidx == 3'd5) ? S_DONE : S_FIXUP;
                    else if (r_last) w_next = S_FIXUP;
                    else             w_next = S_DATA;
`else
                    w_next = r_last ? S_DONE : S_DATA;
`endif
                end else if (w_tmo) begin
`ifdef MYC64_PRG_LOADER_FIXUP_EN
                    w_next = (r_last | r_fix) ? S_ERR : S_DRAIN;
`else
                    w_next = r_last ? S_ERR : S_DRAIN;
`endif
                end
            end
            S_DRAIN:  if (w_xfer && i_byte_last) w_next = S_ERR;
            S_DONE:   w_next = S_HDR_LO;
            S_ERR:    w_next = S_HDR_LO;
`ifdef MYC64_PRG_LOADER_FIXUP_EN
            S_FIXUP:  w_next = S_WRITE;
`endif
            default:  w_next = S_HDR_LO;
        endcase
    end

    // Byte-ready is registered from the next state, so it never follows i_byte_valid
    always_comb begin
        w_rdy_nxt = (w_next == S_HDR_LO) || (w_next == S_HDR_HI) ||
                    (w_next == S_DATA)   || (w_next == S_DRAIN);
    end

    // Address, write port, timeout counter and fixup sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_ready <= 1'b1;
            r_addr       <= '0;
            r_last       <= 1'b0;
            r_cnt        <= '0;
            r_ext_we     <= 1'b0;
            r_ext_addr   <= '0;
            r_ext_data   <= '0;
`ifdef MYC64_PRG_LOADER_FIXUP_EN
            r_fix        <= 1'b0;
            r_fidx       <= '0;
`endif
        end else begin
            r_byte_ready <= w_rdy_nxt;
            case (r_state)
                S_HDR_LO: if (w_xfer) r_addr[7:0]  <= i_byte_data;
                S_HDR_HI: if (w_xfer) r_addr[15:8] <= i_byte_data;
                S_DATA: begin
                    if (w_xfer) begin
                        r_ext_data <= i_byte_data;
                        r_ext_addr <= r_addr;
                        r_ext_we   <= 1'b1;
                        r_last     <= i_byte_last;
                        r_cnt      <= '0;
                    end
                end
                S_WRITE: begin
                    if (i_ext_ready) begin
                        r_ext_we <= 1'b0;
`ifdef MYC64_PRG_LOADER_FIXUP_EN
                        if (r_fix) begin
                            r_fidx <= r_fidx + 3'd1;
                        end else begin
                            r_addr <= r_addr + 16'd1;
                            if (r_last) begin
                                r_fix  <= 1'b1;
                                r_fidx <= '0;
                            end
                        end
`else
                        r_addr <= r_addr + 16'd1;
`endif
                    end else if (w_tmo) begin
                        r_ext_we <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
`ifdef MYC64_PRG_LOADER_FIXUP_EN
                S_FIXUP: begin
                    r_ext_addr <= FIXUP_BASE + {13'd0, r_fidx};
                    r_ext_data <= r_fidx[0] ? r_addr[15:8] : r_addr[7:0];
                    r_ext_we   <= 1'b1;
                    r_cnt      <= '0;
                end
                S_DONE: r_fix <= 1'b0;
                S_ERR:  r_fix <= 1'b0;
`endif
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_myc64_prg_loader.sv
// Directed bench for myc64_prg_loader with a responding top model.
// Build with MYC64_PRG_LOADER_FIXUP_EN to cover the pointer fixup.
module tb_myc64_prg_loader;

    logic        clk;
    logic        rst;
    logic        i_byte_valid;
    logic [7:0]  i_byte_data;
    logic        i_byte_last;
    logic        o_byte_ready;
    logic        o_ext_we;
    logic [15:0] o_ext_addr;
    logic [7:0]  o_ext_data;
    logic        i_ext_ready;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int n_vec;
    int n_err;
    int done_cnt;
    int err_cnt;
    int we_cyc;
    int we_rise;
    logic prev_we;
    bit m_en;
    int mcnt;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];

    myc64_prg_loader dut (
        .clk          (clk),
        .rst          (rst),
        .i_byte_valid (i_byte_valid),
        .i_byte_data  (i_byte_data),
        .i_byte_last  (i_byte_last),
        .o_byte_ready (o_byte_ready),
        .o_ext_we     (o_ext_we),
        .o_ext_addr   (o_ext_addr),
        .o_ext_data   (o_ext_data),
        .i_ext_ready  (i_ext_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge
    initial begin
        done_cnt = 0;
        err_cnt  = 0;
        we_cyc   = 0;
        we_rise  = 0;
        prev_we  = 1'b0;
    end
    always @(negedge clk) begin
        if (o_done) done_cnt <= done_cnt + 1;
        if (o_err) err_cnt <= err_cnt + 1;
        if (o_ext_we) we_cyc <= we_cyc + 1;
        if (o_ext_we && !prev_we) we_rise <= we_rise + 1;
        prev_we <= o_ext_we;
    end

    // Top model: acknowledges a write 3 clk after o_ext_we is seen
    initial begin
        i_ext_ready = 1'b0;
        mcnt = 0;
        forever begin
            @(negedge clk);
            if (i_ext_ready) begin
                i_ext_ready = 1'b0;
            end else if (m_en && o_ext_we) begin
                mcnt++;
                if (mcnt == 3) begin
                    i_ext_ready = 1'b1;
                    wa.push_back(o_ext_addr);
                    wd.push_back(o_ext_data);
                    mcnt = 0;
                end
            end else begin
                mcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at a falling edge
    task automatic send_byte(input logic [7:0] d, input logic l);
        bit ok;
        ok = 1'b0;
        i_byte_valid = 1'b1;
        i_byte_data  = d;
        i_byte_last  = l;
        for (int i = 0; i < 200; i++) begin
            if (o_byte_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        i_byte_valid = 1'b0;
        i_byte_last  = 1'b0;
        if (!ok) check("xfer", 32'(ok), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (!o_busy) break;
            @(negedge clk);
        end
        check("idle", 32'(o_busy), 32'd0);
    endtask

    int b;
    int d0;
    int e0;
    int c0;
    int r0;

    task automatic snap();
        b  = wa.size();
        d0 = done_cnt;
        e0 = err_cnt;
        c0 = we_cyc;
        r0 = we_rise;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_en  = 1'b1;
        rst   = 1'b1;
        i_byte_valid = 1'b0;
        i_byte_data  = 8'h00;
        i_byte_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(o_ext_we), 32'd0);
        check("rst_addr", 32'(o_ext_addr), 32'd0);
        check("rst_data", 32'(o_ext_data), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rdy_idle", 32'(o_byte_ready), 32'd1);

        // Basic file
        snap();
        send_byte(8'h01, 1'b0);
        send_byte(8'h08, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        wait_idle();
`ifdef MYC64_PRG_LOADER_FIXUP_EN
        check("t1_nwr", 32'(wa.size() - b), 32'd8);
`else
        check("t1_nwr", 32'(wa.size() - b), 32'd2);
`endif
        check("t1_a0", 32'(wa[b]), 32'h0801);
        check("t1_d0", 32'(wd[b]), 32'hAA);
        check("t1_a1", 32'(wa[b+1]), 32'h0802);
        check("t1_d1", 32'(wd[b+1]), 32'hBB);
`ifdef MYC64_PRG_LOADER_FIXUP_EN
        for (int k = 0; k < 6; k++) begin
            logic [15:0] ea;
            logic [7:0]  ed;
            ea = 16'h002D + 16'(k);
            ed = (k % 2 == 1) ? 8'h08 : 8'h03;
            check("fix_a", 32'(wa[b+2+k]), 32'(ea));
            check("fix_d", 32'(wd[b+2+k]), 32'(ed));
        end
`endif
        check("t1_done", 32'(done_cnt - d0), 32'd1);
        check("t1_err", 32'(err_cnt - e0), 32'd0);

        // Empty payload
        snap();
        send_byte(8'h00, 1'b0);
        send_byte(8'hC0, 1'b1);
        wait_idle();
        check("t3_we", 32'(we_rise - r0), 32'd0);
        check("t3_err", 32'(err_cnt - e0), 32'd1);
        check("t3_done", 32'(done_cnt - d0), 32'd0);

        // Address wrap, also proves a new file is taken after an error
        snap();
        send_byte(8'hFF, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        wait_idle();
        check("t2_a0", 32'(wa[b]), 32'hFFFF);
        check("t2_d0", 32'(wd[b]), 32'h11);
        check("t2_a1", 32'(wa[b+1]), 32'h0000);
        check("t2_d1", 32'(wd[b+1]), 32'h22);
        check("t2_done", 32'(done_cnt - d0), 32'd1);
        check("t2_err", 32'(err_cnt - e0), 32'd0);

        // Write timeout then drain
        m_en = 1'b0;
        snap();
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        send_byte(8'h77, 1'b1);
        wait_idle();
        check("t4_wecyc", 32'(we_cyc - c0), 32'd64);
        check("t4_werise", 32'(we_rise - r0), 32'd1);
        check("t4_nwr", 32'(wa.size() - b), 32'd0);
        check("t4_err", 32'(err_cnt - e0), 32'd1);
        check("t4_done", 32'(done_cnt - d0), 32'd0);

        // Reset in the middle of a write
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h55, 1'b0);
        check("t5_we_pre", 32'(o_ext_we), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_we", 32'(o_ext_we), 32'd0);
        check("t5_busy", 32'(o_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        m_en = 1'b1;
        @(negedge clk);
        snap();
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h01, 1'b1);
        wait_idle();
        check("t5_a0", 32'(wa[b]), 32'h2000);
        check("t5_d0", 32'(wd[b]), 32'h01);
        check("t5_done", 32'(done_cnt - d0), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
